// File: rtl/lcd_timing_pkg.sv
// Shared constants and types for the 480x272 LCD timing generator.
// Default panel timing, counter widths, sync polarity and the registered
// decode bundle used by lcd_timing_gen.
package lcd_timing_pkg;

    // Default horizontal timing, in pixel clocks
    localparam int unsigned H_ACTIVE_DEF = 480;
    localparam int unsigned H_FP_DEF     = 2;
    localparam int unsigned H_SYNC_DEF   = 41;
    localparam int unsigned H_BP_DEF     = 2;

    // Default vertical timing, in lines
    localparam int unsigned V_ACTIVE_DEF = 272;
    localparam int unsigned V_FP_DEF     = 2;
    localparam int unsigned V_SYNC_DEF   = 10;
    localparam int unsigned V_BP_DEF     = 2;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Counter and coordinate widths
    localparam int unsigned HCNT_W = 10;
    localparam int unsigned VCNT_W = 9;
    localparam int unsigned PIX_W  = 9;

    // Panel syncs are active-low
    localparam logic SYNC_ACTIVE = 1'b0;
    localparam logic SYNC_IDLE   = 1'b1;

    // Decode of one (h,v) position, registered as a unit
    typedef struct packed {
        logic [PIX_W-1:0] x;
        logic [PIX_W-1:0] y;
        logic             hde;
        logic             vde;
        logic             de;
        logic             hsync;
        logic             vsync;
        logic             line_start;
        logic             frame_start;
    } timing_t;

    localparam timing_t TIMING_RST = '{
        x:           '0,
        y:           '0,
        hde:         1'b0,
        vde:         1'b0,
        de:          1'b0,
        hsync:       SYNC_IDLE,
        vsync:       SYNC_IDLE,
        line_start:  1'b0,
        frame_start: 1'b0
    };

endpackage

// File: rtl/sig_delay_line.sv
// Single-bit shift register with a configurable depth and reset level.
// Used to line sync/DE up with downstream ROM read latency.
module sig_delay_line #(
    parameter int unsigned Depth  = 2,
    parameter logic        RstVal = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [Depth-1:0] stage_q;
    logic [Depth-1:0] stage_d;

    // Shift one stage per clock; stage 0 takes the input
    if (Depth == 1) begin : g_single
        assign stage_d = i_d;
    end else begin : g_chain
        assign stage_d = {stage_q[Depth-2:0], i_d};
    end

    // Stage registers; every stage clears to the signal's inactive level
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stage_q <= {Depth{RstVal}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign o_q = stage_q[Depth-1];

endmodule

// File: rtl/lcd_timing_gen.sv
// Single-clock horizontal/vertical timing generator for a parallel RGB LCD.
// Both counters run on the pixel clock; outputs are the registered decode of
// the current (h,v), so they lag the counters by one clock. Sync and DE are
// also provided through PIPE_DELAY-deep delay lines to match ROM latency.
// Optional frame counter on o_frame: define LCD_TIMING_FRAME_CNT_EN.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned H_FP       = H_FP_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BP       = H_BP_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned V_FP       = V_FP_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BP       = V_BP_DEF,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [PIX_W-1:0] o_x,
    output logic [PIX_W-1:0] o_y,
    output logic             o_hde,
    output logic             o_vde,
    output logic             o_de,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_line_start,
    output logic             o_frame_start,
    output logic             o_hsync_d,
    output logic             o_vsync_d,
    output logic             o_de_d,
    output logic [7:0]       o_frame
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Refuse to elaborate timings the counters cannot represent
    if (H_TOTAL > (1 << HCNT_W)) begin : g_bad_h_total
        $error("lcd_timing_gen: H_TOTAL does not fit the horizontal counter");
    end
    if (V_TOTAL > (1 << VCNT_W)) begin : g_bad_v_total
        $error("lcd_timing_gen: V_TOTAL does not fit the vertical counter");
    end
    if (H_ACTIVE > (1 << PIX_W)) begin : g_bad_h_active
        $error("lcd_timing_gen: H_ACTIVE does not fit the x coordinate");
    end
    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_pipe
        $error("lcd_timing_gen: PIPE_DELAY must be within 1..4");
    end

    // Decode thresholds, pre-sized to the counter widths
    localparam logic [HCNT_W-1:0] H_LAST     = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_ACT_END  = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] H_SYNC_BEG = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] H_SYNC_END = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCNT_W-1:0] V_LAST     = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_ACT_END  = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] V_SYNC_BEG = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] V_SYNC_END = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [HCNT_W-1:0] h_q, h_d;
    logic [VCNT_W-1:0] v_q, v_d;
    logic              frame_wrap;
    timing_t           dec;
    timing_t           tim_q;

    // Counter advance: h wraps every line, v steps on the h wrap
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    assign frame_wrap = (h_q == H_LAST) && (v_q == V_LAST);

    // Decode the current position into the output bundle
    always_comb begin
        dec             = TIMING_RST;
        dec.hde         = (h_q < H_ACT_END);
        dec.vde         = (v_q < V_ACT_END);
        dec.de          = dec.hde & dec.vde;
        dec.hsync       = (h_q >= H_SYNC_BEG && h_q < H_SYNC_END) ? SYNC_ACTIVE : SYNC_IDLE;
        // vsync spans whole lines, so its edges fall on h=0
        dec.vsync       = (v_q >= V_SYNC_BEG && v_q < V_SYNC_END) ? SYNC_ACTIVE : SYNC_IDLE;
        dec.x           = dec.hde ? h_q[PIX_W-1:0] : '0;
        dec.y           = dec.vde ? v_q : '0;
        dec.line_start  = (h_q == '0);
        dec.frame_start = (h_q == '0) && (v_q == '0);
    end

    // Counters and output register; reset drops all state regardless of position
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            h_q   <= '0;
            v_q   <= '0;
            tim_q <= TIMING_RST;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            tim_q <= dec;
        end
    end

    assign o_x           = tim_q.x;
    assign o_y           = tim_q.y;
    assign o_hde         = tim_q.hde;
    assign o_vde         = tim_q.vde;
    assign o_de          = tim_q.de;
    assign o_hsync       = tim_q.hsync;
    assign o_vsync       = tim_q.vsync;
    assign o_line_start  = tim_q.line_start;
    assign o_frame_start = tim_q.frame_start;

    // Delayed copies of the registered syncs and DE for the ROM data path
    sig_delay_line #(
        .Depth  (PIPE_DELAY),
        .RstVal (SYNC_IDLE)
    ) u_hsync_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (tim_q.hsync),
        .o_q     (o_hsync_d)
    );

    sig_delay_line #(
        .Depth  (PIPE_DELAY),
        .RstVal (SYNC_IDLE)
    ) u_vsync_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (tim_q.vsync),
        .o_q     (o_vsync_d)
    );

    sig_delay_line #(
        .Depth  (PIPE_DELAY),
        .RstVal (1'b0)
    ) u_de_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (tim_q.de),
        .o_q     (o_de_d)
    );

`ifdef LCD_TIMING_FRAME_CNT_EN
    logic [7:0] frame_q, frame_d;

    // Count completed frames; steps on the same edge the counters wrap to (0,0)
    always_comb begin
        frame_d = frame_q;
        if (frame_wrap) begin
            frame_d = frame_q + 8'd1;
        end
    end

    // Frame counter register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            frame_q <= 8'd0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign o_frame = frame_q;
`else
    logic unused_frame_wrap;
    assign unused_frame_wrap = frame_wrap;
    assign o_frame           = 8'd0;
`endif

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
Single-clock horizontal/vertical timing generator for the 480x272 parallel RGB LCD path. It replaces the ripple-clocked pair where the vertical counter is clocked by hsync: both counters run on the pixel clock. It produces pixel coordinates for the ROM address stage, plus sync/DE outputs pre-delayed to match ROM read latency. It sits directly upstream of ROM addressing, palette lookup and the LCD pins.

Parameters:
H_ACTIVE, 480, visible pixels per line
H_FP, 2, horizontal front porch (clocks)
H_SYNC, 41, hsync pulse width (clocks)
H_BP, 2, horizontal back porch (clocks)
V_ACTIVE, 272, visible lines per frame
V_FP, 2, vertical front porch (lines)
V_SYNC, 10, vsync pulse width (lines)
V_BP, 2, vertical back porch (lines)
PIPE_DELAY, 2, pipeline stages applied to the *_d outputs; legal range 1..4

Ports:
i_clk  in  1  pixel clock (LCD_CLK)
i_rst_n  in  1  synchronous reset, active-low
o_x  out  9  pixel column; 0 outside the active line
o_y  out  9  pixel row; 0 outside the active frame
o_hde  out  1  horizontal active region
o_vde  out  1  vertical active region
o_de  out  1  o_hde & o_vde
o_hsync  out  1  horizontal sync, active-low
o_vsync  out  1  vertical sync, active-low
o_line_start  out  1  one-cycle pulse at h=0 of every line
o_frame_start  out  1  one-cycle pulse at h=0, v=0
o_hsync_d  out  1  o_hsync delayed by PIPE_DELAY clocks
o_vsync_d  out  1  o_vsync delayed by PIPE_DELAY clocks
o_de_d  out  1  o_de delayed by PIPE_DELAY clocks
o_frame  out  8  frame counter (see Optional Feature)

Behaviour:
- Single clock domain; reset is synchronous and active-low. All state changes on the rising edge of i_clk.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 525); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 286).
- Internal counters: h is 10 bits, range 0..H_TOTAL-1; v is 9 bits, range 0..V_TOTAL-1.
- Edge with i_rst_n=0:
  - h and v are set to 0.
  - Outputs take their reset values: o_x=0, o_y=0, o_hde=0, o_vde=0, o_de=0, o_hsync=1, o_vsync=1, o_line_start=0, o_frame_start=0.
  - All delay-line stages are cleared: o_hsync_d=1, o_vsync_d=1, o_de_d=0.
  - o_frame=0.
  - Reset asserted mid-line or mid-frame behaves the same way: no partial-state retention.
- Edge with i_rst_n=1:
  - Every output register loads the decode of the current (h,v); counters then advance.
  - Outputs therefore lag the counters by exactly 1 clock.
  - The first clock after reset release shows (0,0): o_de=1, o_line_start=1, o_frame_start=1.
- Counter advance:
  - h<=h+1.
  - At h=H_TOTAL-1: h<=0 and v<=v+1.
  - At h=H_TOTAL-1 and v=V_TOTAL-1: both wrap to 0 on the same edge.
- Decode:
  - hde = h<H_ACTIVE
  - vde = v<V_ACTIVE
  - hsync low for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (default h 482..522)
  - vsync low for whole lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (default v 274..283); edges aligned to h=0
  - x = hde ? h[8:0] : 0
  - y = vde ? v : 0
- Delay line:
  - PIPE_DELAY-deep shift registers on hsync, vsync and de.
  - Each stage's reset value is the inactive level of its signal.
  - With PIPE_DELAY=2, *_d lines up with rom_4c registered-output data for the address formed from o_x/o_y.
- Illegal parameters: if any total exceeds its counter width, or PIPE_DELAY is outside 1..4, elaboration must fail (generate-time error).

Optional Feature:
- Macro: LCD_TIMING_FRAME_CNT_EN.
- Defined:
  - o_frame is an 8-bit counter that increments on the edge where (h,v) wraps from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - It wraps 255->0 and is cleared by reset, so the first frame after reset reads 0.
- Undefined:
  - o_frame is tied to 8'd0 and no counter logic is generated.
  - The port remains, so the interface is unchanged.

Decomposition:
- Package lcd_timing_pkg holds:
  - default timing constants (480/2/41/2, 272/2/10/2)
  - sync active level (0) and derived H_TOTAL/V_TOTAL
  - counter widths (10/9)
- One sub-module, sig_delay_line: parameterised depth and reset value, 1-bit shift register, instantiated 3 times.

Test Plan:
1. Reset held 5 clocks, then released -> first active cycle shows o_x=0, o_y=0, o_de=1, o_frame_start=1, o_hsync=1; all *_d outputs hold reset values for 2 clocks.
2. Run one line -> o_hde high 480 clocks; o_hsync low exactly 41 clocks starting 482 clocks after o_line_start; o_line_start period is 525 clocks.
3. Run one full frame -> o_frame_start period is 150150 clocks; o_vsync low for 10*525=5250 clocks starting at line 274 h=0; o_de high 480*272 clocks.
4. Compare *_d against the undelayed outputs -> o_de_d(t)=o_de(t-2), o_hsync_d(t)=o_hsync(t-2), o_vsync_d(t)=o_vsync(t-2) throughout; repeat with PIPE_DELAY=1 and PIPE_DELAY=4.
5. Assert reset at line 100, h=300 for 1 clock -> next active cycle restarts at (0,0) with o_frame_start=1; with the macro defined, o_frame=0.
6. Small parameters (H 4/1/2/1, V 3/1/1/1) with LCD_TIMING_FRAME_CNT_EN, 260 frames -> boundary wrap at (7,5)->(0,0); o_frame reaches 255 then 0; o_y/o_x are 0 in blanking.
